// File: rtl/registers_unit_pkg.sv
// Shared constants, index type and bypass-match helper for the register file.
package registers_unit_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;
    localparam int SP_IDX    = 2;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_03FC;

    localparam int ZERO = 0;
    localparam int RA   = 1;
    localparam int SP   = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // A read forwards the write data only for a live write to a real register.
    function automatic logic bypass_hit(input logic wr_en, input reg_idx_t wr_idx,
                                        input reg_idx_t rd_idx);
        return wr_en && (wr_idx != '0) && (wr_idx == rd_idx);
    endfunction

endpackage

// File: rtl/registers_unit_if.sv
// Read, write and debug signals of the register file bundled as one interface.
interface registers_unit_if #(parameter int XLEN = 32);

    logic [4:0]      RUrs1;
    logic [4:0]      RUrs2;
    logic [4:0]      RUrd;
    logic [XLEN-1:0] RUDataWr;
    logic            RUWr;
    logic [4:0]      RUDbgAddr;
    logic [XLEN-1:0] RURs1;
    logic [XLEN-1:0] RURs2;
    logic [XLEN-1:0] RUDbgData;
    logic [31:0]     RUWrCount;

    modport master (
        output RUrs1, RUrs2, RUrd, RUDataWr, RUWr, RUDbgAddr,
        input  RURs1, RURs2, RUDbgData, RUWrCount
    );

    modport slave (
        input  RUrs1, RUrs2, RUrd, RUDataWr, RUWr, RUDbgAddr,
        output RURs1, RURs2, RUDbgData, RUWrCount
    );

endinterface

// File: rtl/registers_unit_read_port.sv
// One combinational read port: array select with optional write-through forwarding.
module registers_unit_read_port
    import registers_unit_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int BYPASS = 0
) (
    input  logic [REG_COUNT-1:0][XLEN-1:0] regs,
    input  reg_idx_t                       idx,
    input  logic                           wr_en,
    input  reg_idx_t                       wr_idx,
    input  logic [XLEN-1:0]                wr_data,
    output logic [XLEN-1:0]                data
);

    // x0 is forced last so neither forwarding nor storage can ever make it non-zero.
    always_comb begin
        data = regs[idx];
        if ((BYPASS != 0) && bypass_hit(wr_en, wr_idx, idx)) begin
            data = wr_data;
        end
        if (idx == REG_IDX_W'(ZERO)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/registers_unit.sv
// 32 x XLEN register file with two read ports, a debug port and a saturating write counter.
module registers_unit
    import registers_unit_pkg::*;
#(
    parameter int              XLEN    = XLEN_DEF,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
    parameter int              BYPASS  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    registers_unit_if.slave  bus
);

    logic [REG_COUNT-1:0][XLEN-1:0] regs;
    logic [31:0]                    wr_count;
    logic                           commit;
    logic                           live_wr;
    logic [XLEN-1:0]                rs1_data;
    logic [XLEN-1:0]                rs2_data;
    logic [XLEN-1:0]                dbg_data;

    assign commit  = bus.RUWr && (bus.RUrd != '0);
    // Reset overrides any write, so forwarding is also suppressed while held.
    assign live_wr = bus.RUWr && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            regs[SP_IDX] <= SP_INIT;
        end else if (commit) begin
            regs[bus.RUrd] <= bus.RUDataWr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (commit && (wr_count != 32'hFFFF_FFFF)) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    registers_unit_read_port #(.XLEN(XLEN), .BYPASS(BYPASS)) u_rs1 (
        .regs    (regs),
        .idx     (bus.RUrs1),
        .wr_en   (live_wr),
        .wr_idx  (bus.RUrd),
        .wr_data (bus.RUDataWr),
        .data    (rs1_data)
    );

    registers_unit_read_port #(.XLEN(XLEN), .BYPASS(BYPASS)) u_rs2 (
        .regs    (regs),
        .idx     (bus.RUrs2),
        .wr_en   (live_wr),
        .wr_idx  (bus.RUrd),
        .wr_data (bus.RUDataWr),
        .data    (rs2_data)
    );

    registers_unit_read_port #(.XLEN(XLEN), .BYPASS(BYPASS)) u_dbg (
        .regs    (regs),
        .idx     (bus.RUDbgAddr),
        .wr_en   (live_wr),
        .wr_idx  (bus.RUrd),
        .wr_data (bus.RUDataWr),
        .data    (dbg_data)
    );

    assign bus.RURs1     = rs1_data;
    assign bus.RURs2     = rs2_data;
    assign bus.RUDbgData = dbg_data;
    assign bus.RUWrCount = wr_count;

endmodule

// File: tb/tb_registers_unit.sv
// Directed bench for registers_unit: write-through and plain variants against a scoreboard model.
module tb_registers_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    registers_unit_if #(.XLEN(32)) bus0 ();
    registers_unit_if #(.XLEN(32)) bus1 ();

    registers_unit #(.XLEN(32), .SP_INIT(32'h0000_03FC), .BYPASS(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    registers_unit #(.XLEN(32), .SP_INIT(32'h0000_03FC), .BYPASS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt0;
    logic [31:0] m_cnt1;

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : m_regs[idx];
    endfunction

    function automatic logic [31:0] m_byp(input logic [4:0] idx, input logic live,
                                          input logic wr, input logic [4:0] rd,
                                          input logic [31:0] data);
        if (live && wr && (rd != 5'd0) && (rd == idx)) return data;
        return m_read(idx);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_regs[2] = 32'h0000_03FC;
        m_cnt0 = 32'd0;
        m_cnt1 = 32'd0;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    task automatic check_output(input logic [31:0] observed);
        logic [31:0] expected;
        string       tag;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
            return;
        end
        expected = exp_q.pop_front();
        tag      = tag_q.pop_front();
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle on both DUTs, check same-cycle outputs, then let the edge commit.
    task automatic apply_stimulus(input string step, input logic rst, input logic wr,
                                  input logic [4:0] rd, input logic [31:0] data,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] dbg);
        @(negedge clk);
        rst_n          = rst;
        bus0.RUWr      = wr;  bus1.RUWr      = wr;
        bus0.RUrd      = rd;  bus1.RUrd      = rd;
        bus0.RUDataWr  = data; bus1.RUDataWr = data;
        bus0.RUrs1     = rs1; bus1.RUrs1     = rs1;
        bus0.RUrs2     = rs2; bus1.RUrs2     = rs2;
        bus0.RUDbgAddr = dbg; bus1.RUDbgAddr = dbg;
        if (!rst) m_reset();

        push_exp({step, "_d0_rs1"}, m_read(rs1));
        push_exp({step, "_d0_rs2"}, m_read(rs2));
        push_exp({step, "_d0_dbg"}, m_read(dbg));
        push_exp({step, "_d0_cnt"}, m_cnt0);
        push_exp({step, "_d1_rs1"}, m_byp(rs1, rst, wr, rd, data));
        push_exp({step, "_d1_rs2"}, m_byp(rs2, rst, wr, rd, data));
        push_exp({step, "_d1_dbg"}, m_byp(dbg, rst, wr, rd, data));
        push_exp({step, "_d1_cnt"}, m_cnt1);

        #1;
        check_output(bus0.RURs1);
        check_output(bus0.RURs2);
        check_output(bus0.RUDbgData);
        check_output(bus0.RUWrCount);
        check_output(bus1.RURs1);
        check_output(bus1.RURs2);
        check_output(bus1.RUDbgData);
        check_output(bus1.RUWrCount);

        @(posedge clk);
        if (rst && wr && (rd != 5'd0)) begin
            m_regs[rd] = data;
            if (m_cnt0 != 32'hFFFF_FFFF) m_cnt0 = m_cnt0 + 32'd1;
            if (m_cnt1 != 32'hFFFF_FFFF) m_cnt1 = m_cnt1 + 32'd1;
        end
    endtask

    initial begin
        bus0.RUWr = 1'b0; bus0.RUrd = '0; bus0.RUDataWr = '0;
        bus0.RUrs1 = '0;  bus0.RUrs2 = '0; bus0.RUDbgAddr = '0;
        bus1.RUWr = 1'b0; bus1.RUrd = '0; bus1.RUDataWr = '0;
        bus1.RUrs1 = '0;  bus1.RUrs2 = '0; bus1.RUDbgAddr = '0;
        m_reset();

        apply_stimulus("rst_vals",   1'b0, 1'b0, 5'd0,  32'h0,         5'd2,  5'd0, 5'd5);
        apply_stimulus("first_wr",   1'b1, 1'b1, 5'd4,  32'h0000_0055, 5'd4,  5'd2, 5'd0);
        apply_stimulus("wr_x5",      1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5, 5'd4);
        apply_stimulus("rd_x5",      1'b1, 1'b0, 5'd0,  32'h0,         5'd5,  5'd5, 5'd5);
        apply_stimulus("wr_x0",      1'b1, 1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd0, 5'd0);
        apply_stimulus("wr_x7",      1'b1, 1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd7, 5'd7);
        apply_stimulus("wr_x31",     1'b1, 1'b1, 5'd31, 32'h8000_0000, 5'd7,  5'd7, 5'd7);
        apply_stimulus("wr_ra",      1'b1, 1'b1, 5'd1,  32'h0000_FFFF, 5'd31, 5'd2, 5'd31);
        apply_stimulus("rd_mix",     1'b1, 1'b0, 5'd0,  32'h0,         5'd1,  5'd5, 5'd7);
        apply_stimulus("mid_rst",    1'b0, 1'b0, 5'd0,  32'h0,         5'd5,  5'd2, 5'd7);
        apply_stimulus("post_rst",   1'b1, 1'b0, 5'd0,  32'h0,         5'd5,  5'd2, 5'd4);
        apply_stimulus("rst_vs_wr",  1'b0, 1'b1, 5'd3,  32'h0000_0001, 5'd3,  5'd3, 5'd3);
        apply_stimulus("rd_x3",      1'b1, 1'b0, 5'd0,  32'h0,         5'd3,  5'd2, 5'd0);

        // Preload the plain DUT's counter near its ceiling between edges.
        #2;
        force dut0.wr_count = 32'hFFFF_FFFE;
        #1;
        release dut0.wr_count;
        m_cnt0 = 32'hFFFF_FFFE;

        apply_stimulus("sat_wr1",    1'b1, 1'b1, 5'd9,  32'hCAFE_F00D, 5'd9,  5'd0, 5'd9);
        apply_stimulus("sat_wr2",    1'b1, 1'b1, 5'd9,  32'h0BAD_F00D, 5'd9,  5'd9, 5'd9);
        apply_stimulus("sat_hold",   1'b1, 1'b0, 5'd0,  32'h0,         5'd9,  5'd9, 5'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/registers_unit.md
REGISTERS_UNIT -- requirements
Module: RegistersUnit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, the register data width.
REQ-002 The module SHALL have parameter SP_INIT, default 32'h0000_03FC, the reset value of x2 (sp).
REQ-003 The module SHALL have parameter BYPASS, default 0; 1 selects write-through on the read ports.
REQ-004 Ports: clk  input  1  single clock, all state updates on rising edge.
REQ-005 Ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Ports: RUrs1  input  5  read-port-1 register index.
REQ-007 Ports: RUrs2  input  5  read-port-2 register index.
REQ-008 Ports: RUrd  input  5  write register index.
REQ-009 Ports: RUDataWr  input  XLEN  writeback data from the writeback data mux.
REQ-010 Ports: RUWr  input  1  write enable.
REQ-011 Ports: RUDbgAddr  input  5  debug read index.
REQ-012 Ports: RURs1  output  XLEN  register[RUrs1].
REQ-013 Ports: RURs2  output  XLEN  register[RUrs2].
REQ-014 Ports: RUDbgData  output  XLEN  register[RUDbgAddr].
REQ-015 Ports: RUWrCount  output  32  count of committed non-x0 writes, saturating.
REQ-016 One clock; reset is asynchronous and active-low.

Function
REQ-017 The block SHALL hold 32 registers x0..x31 of XLEN bits.
REQ-018 On a rising clk edge with RUWr=1 and RUrd!=0, register[RUrd] SHALL take RUDataWr.
REQ-019 Writes with RUrd=0 SHALL be discarded; x0 SHALL always read 0.
REQ-020 RUWr=0 SHALL leave all registers and RUWrCount unchanged.
REQ-021 Read ports SHALL be combinational (zero-cycle latency) from current register state.
REQ-022 With BYPASS=0, a read of RUrd in the write cycle SHALL return the old value; the new value is visible after the edge.
REQ-023 With BYPASS=1, when RUWr=1, RUrd!=0 and a read index equals RUrd, that port SHALL return RUDataWr in the same cycle.
REQ-024 Bypass SHALL never apply to index 0.
REQ-025 Simultaneous equal indices on all read ports SHALL return identical values.
REQ-026 RUWrCount SHALL increment by 1 on each committed non-x0 write.
REQ-027 RUWrCount SHALL saturate at 32'hFFFF_FFFF, never wrapping to 0.
REQ-028 Data SHALL be stored bit-exact; no sign or zero extension.
REQ-029 Inputs with X/Z on RUWr SHALL NOT be required to hold state (verification treats as illegal stimulus).

Reset
REQ-030 While rst_n=0, all registers SHALL be 0 except x2=SP_INIT, and RUWrCount SHALL be 0.
REQ-031 Reset SHALL act immediately on assertion, independent of clk, and override a same-cycle write.
REQ-032 Outputs SHALL reflect reset values combinationally during reset.
REQ-033 The first write SHALL commit on the first rising clk edge after rst_n deasserts.

Structure
REQ-034 A shared package SHALL define XLEN_DEF=32, REG_COUNT=32, REG_IDX_W=5, SP_IDX=2, SP_INIT_DEF.
REQ-035 The same package SHALL define localparams for ABI indices used by tests (ZERO=0, RA=1, SP=2).
REQ-036 One sub-module is natural: RegReadPort (index + optional bypass select), instantiated three times.
REQ-037 No memory macro; flop array with async reset.

Verification
REQ-038 Reset: assert rst_n=0 mid-run after writes -> all reads 0, x2=0x3FC, RUWrCount=0 without a clk edge.
REQ-039 Write x5=0xDEADBEEF with RUWr=1 -> RURs1(rs1=5) old value same cycle (BYPASS=0), 0xDEADBEEF next cycle; RUWrCount=1.
REQ-040 Write x0=0x12345678 -> RURs1(rs1=0)=0, RUWrCount unchanged.
REQ-041 BYPASS=1: write x7=0xA5A5A5A5 with rs1=rs2=dbg=7 -> all three outputs 0xA5A5A5A5 same cycle.
REQ-042 Preload RUWrCount to 0xFFFFFFFE via force, two writes to x9 -> count 0xFFFFFFFF, stays.
REQ-043 rst_n asserted in same cycle as write x3=0x1 -> x3 reads 0 after the edge.
